// File: rtl/wb_pipe_if.sv
// Write-back pipeline bus: memory-stage results in, registered write-back results out.
// The stall vector range comes from `StallBus, defaulting to 7:0 when no project header provides it.
`ifndef StallBus
`define StallBus 7:0
`endif

interface wb_pipe_if #(
    parameter int NCH = 2,
    parameter int AW  = 5,
    parameter int DW  = 32
);
    logic [NCH*AW-1:0] mem_wd;
    logic [NCH-1:0]    mem_wreg;
    logic [NCH*DW-1:0] mem_wdata;
    logic [NCH*AW-1:0] wb_wd;
    logic [NCH-1:0]    wb_wreg;
    logic [NCH*DW-1:0] wb_wdata;
    logic              wb_valid;

    modport master (
        output mem_wd, mem_wreg, mem_wdata,
        input  wb_wd, wb_wreg, wb_wdata, wb_valid
    );

    modport slave (
        input  mem_wd, mem_wreg, mem_wdata,
        output wb_wd, wb_wreg, wb_wdata, wb_valid
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register for NCH write-back channels with stall/flush control.
// Optional performance counters are enabled by defining WB_PERF_CNT_EN.
`ifndef StallBus
`define StallBus 7:0
`endif

module wb_pipe_reg #(
    parameter int NCH   = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int STAGE = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [`StallBus] stall_sign_i,
    input  logic            flush_i,
    wb_pipe_if.slave        bus
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o
`endif
);

    localparam int SB_W = $bits(stall_sign_i);

    if ((STAGE < 0) || ((STAGE + 1) >= SB_W)) begin : g_stage_range_err
        $error("wb_pipe_reg: STAGE+1 lies outside the stall vector");
    end
    if ((NCH < 1) || (NCH > 4)) begin : g_nch_range_err
        $error("wb_pipe_reg: NCH must be 1..4");
    end

    logic              stall_here_s;
    logic              stall_next_s;
    logic              clear_s;
    logic              advance_s;
    logic [NCH-1:0]    wreg_filt_s;

    logic [NCH*AW-1:0] wb_wd_q,    wb_wd_d;
    logic [NCH-1:0]    wb_wreg_q,  wb_wreg_d;
    logic [NCH*DW-1:0] wb_wdata_q, wb_wdata_d;
    logic              wb_valid_q, wb_valid_d;

    assign stall_here_s = stall_sign_i[STAGE];
    assign stall_next_s = stall_sign_i[STAGE+1];
    // Flush and bubble both empty the stage; advance only when this stage is not stalled.
    assign clear_s      = flush_i | (stall_here_s & ~stall_next_s);
    assign advance_s    = ~flush_i & ~stall_here_s;

    // Drop writes to register zero and to addresses a higher-indexed channel also writes.
    always_comb begin
        wreg_filt_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (bus.mem_wreg[i] && (bus.mem_wd[i*AW +: AW] != {AW{1'b0}})) begin
                wreg_filt_s[i] = 1'b1;
            end else begin
                wreg_filt_s[i] = 1'b0;
            end
            for (int j = i + 1; j < NCH; j++) begin
                if (bus.mem_wreg[j] && (bus.mem_wd[j*AW +: AW] == bus.mem_wd[i*AW +: AW])) begin
                    wreg_filt_s[i] = 1'b0;
                end else begin
                    wreg_filt_s[i] = wreg_filt_s[i];
                end
            end
        end
    end

    // Next-state selection: clear, capture, or hold.
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        wb_valid_d = wb_valid_q;
        if (clear_s) begin
            wb_wd_d    = {(NCH*AW){1'b0}};
            wb_wreg_d  = {NCH{1'b0}};
            wb_wdata_d = {(NCH*DW){1'b0}};
            wb_valid_d = 1'b0;
        end else if (advance_s) begin
            wb_wd_d    = bus.mem_wd;
            wb_wreg_d  = wreg_filt_s;
            wb_wdata_d = bus.mem_wdata;
            wb_valid_d = 1'b1;
        end else begin
            wb_valid_d = wb_valid_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_q    <= {(NCH*AW){1'b0}};
            wb_wreg_q  <= {NCH{1'b0}};
            wb_wdata_q <= {(NCH*DW){1'b0}};
            wb_valid_q <= 1'b0;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign bus.wb_wd    = wb_wd_q;
    assign bus.wb_wreg  = wb_wreg_q;
    assign bus.wb_wdata = wb_wdata_q;
    assign bus.wb_valid = wb_valid_q;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Event counters; retire counts only cycles that commit at least one write.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (clear_s) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (advance_s) begin
            if (|wreg_filt_s) begin
                retire_cnt_d = sat_inc(retire_cnt_q);
            end else begin
                retire_cnt_d = retire_cnt_q;
            end
        end else begin
            hold_cnt_d = sat_inc(hold_cnt_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= {CNT_W{1'b0}};
            hold_cnt_q   <= {CNT_W{1'b0}};
            retire_cnt_q <= {CNT_W{1'b0}};
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign hold_cnt_o   = hold_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 Parameter NCH, default 2, number of parallel write-back channels (1..4).
REQ-002 Parameter AW, default 5, register-address width per channel.
REQ-003 Parameter DW, default 32, write-data width per channel.
REQ-004 Parameter STAGE, default 5, index of this stage's bit in stall_sign; bit STAGE+1 is the downstream stage.
REQ-005 Parameter CNT_W, default 16, performance-counter width.
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 stall_sign  in  `StallBus  pipeline stall vector from ctrl.
REQ-009 flush  in  1  clear stage contents (exception/redirect).
REQ-010 mem_wd  in  NCH*AW  destination addresses, channel i at [i*AW +: AW].
REQ-011 mem_wreg  in  NCH  per-channel write enables.
REQ-012 mem_wdata  in  NCH*DW  write data, channel i at [i*DW +: DW].
REQ-013 wb_wd  out  NCH*AW  registered addresses.
REQ-014 wb_wreg  out  NCH  registered write enables.
REQ-015 wb_wdata  out  NCH*DW  registered data.
REQ-016 wb_valid  out  1  stage holds a real (non-bubble) instruction group.
REQ-017 bubble_cnt, hold_cnt, retire_cnt  out  CNT_W each  performance counters (present only with WB_PERF_CNT_EN).

Function
REQ-018 All outputs SHALL be registered on posedge clk; latency mem_* to wb_* is exactly 1 cycle.
REQ-019 Priority per cycle SHALL be: rst > flush > bubble > advance > hold.
REQ-020 Bubble (stall_sign[STAGE]=1, stall_sign[STAGE+1]=0): wb_wd=0, wb_wreg=0, wb_wdata=0, wb_valid=0.
REQ-021 Advance (stall_sign[STAGE]=0): capture all channels, wb_valid=1.
REQ-022 Hold (stall_sign[STAGE]=1, stall_sign[STAGE+1]=1): all outputs keep previous values.
REQ-023 Flush SHALL clear outputs as in bubble regardless of stall_sign.
REQ-024 On capture, a channel with mem_wd=0 SHALL have wb_wreg forced 0 (register zero is read-only); address/data still captured.
REQ-025 On capture, if channels i<j both enabled with equal nonzero address, wb_wreg[i] SHALL be forced 0 (highest index wins); applies pairwise across all channels.
REQ-026 STAGE+1 SHALL lie within `StallBus; out-of-range is a parameter error.

Reset
REQ-027 On rst=1 at posedge clk: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_valid=0, all counters=0.
REQ-028 Reset during hold or flush SHALL win; no captured state survives.

Configuration
REQ-029 Macro WB_PERF_CNT_EN defined: counters present; bubble_cnt +1 per bubble or flush cycle, hold_cnt +1 per hold cycle, retire_cnt +1 per advance cycle with any final wb_wreg bit set; all saturate at 2^CNT_W-1.
REQ-030 WB_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-031 NCH=2; advance with mem_wd={5'd3,5'd7}, mem_wreg=2'b11, data {32'hA,32'hB} -> next cycle outputs equal inputs, wb_valid=1.
REQ-032 stall_sign[5]=1,[6]=0 -> next cycle all wb_* zero, wb_valid=0, bubble_cnt +1.
REQ-033 stall_sign[5]=1,[6]=1 for 3 cycles after capture of 32'hA -> outputs unchanged, hold_cnt=3.
REQ-034 mem_wd={5'd9,5'd9}, mem_wreg=2'b11 -> wb_wreg=2'b10; mem_wd ch0=0, mem_wreg=2'b01 -> wb_wreg=2'b00, retire_cnt unchanged.
REQ-035 flush=1 with stall_sign[5]=1,[6]=1 -> outputs cleared next cycle; rst=1 with flush=1 -> counters also 0.
REQ-036 CNT_W=4, 20 consecutive advance cycles with writes -> retire_cnt saturates at 15.
